trb_mem_ctrl: RTL and testbench

- Memory-side controller directly downstream of the Tracer.
- Consumes the Tracer's store words (DATA/STORE/STORE_PERM) and the trigger info (TRG_EVENT/EVENT_POS), and returns TRG_DELAYED.
- Serves the Tracer's load requests (LOAD_REQUEST/LOAD_GRANT/DATA).
- Holds an internal word memory. Trace mode: circular pre/post-trigger capture buffer. Stream mode: host-fed FIFO.

---
 rtl/trb_mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_trb_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trb_mem_ctrl.sv
// trb_mem_ctrl: memory-side controller behind the Tracer.
// Trace mode captures a circular pre/post-trigger window and lets the host
// read it back oldest-first. Stream mode turns the same word memory into a
// host-fed FIFO that the Tracer drains through one-cycle load grants.
module trb_mem_ctrl #(
  parameter int TRB_WIDTH = 32,
  parameter int TRB_DEPTH = 64,
  localparam int AW = $clog2(TRB_DEPTH),
  localparam int PW = $clog2(TRB_WIDTH)
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 MODE_I,
  input  logic                 ARM_I,
  input  logic [AW-1:0]        DELAY_I,
  input  logic                 STORE_I,
  input  logic [TRB_WIDTH-1:0] DATA_I,
  output logic                 STORE_PERM_O,
  input  logic                 TRG_EVENT_I,
  input  logic [PW-1:0]        EVENT_POS_I,
  output logic                 TRG_DELAYED_O,
  input  logic                 LOAD_REQUEST_I,
  output logic                 LOAD_GRANT_O,
  output logic [TRB_WIDTH-1:0] DATA_O,
  input  logic                 HOST_WR_I,
  input  logic [TRB_WIDTH-1:0] HOST_DATA_I,
  output logic                 HOST_WRITE_READY_O,
  input  logic                 HOST_RD_I,
  output logic [TRB_WIDTH-1:0] HOST_DATA_O,
  output logic                 HOST_READ_VALID_O,
  output logic [AW-1:0]        TRG_ADDR_O,
  output logic [PW-1:0]        TRG_POS_O
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(TRB_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_POST   = 3'd2,
    S_DONE   = 3'd3,
    S_STREAM = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [TRB_WIDTH-1:0] r_mem [TRB_DEPTH];

  logic [AW-1:0]        r_delay;
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [AW:0]          r_fill;
  logic [AW-1:0]        r_post_cnt;
  logic [AW:0]          r_remain;
  logic                 r_store_perm;
  logic                 r_trg_delayed;
  logic                 r_load_grant;
  logic [TRB_WIDTH-1:0] r_data_o;
  logic [AW-1:0]        r_trg_addr;
  logic [PW-1:0]        r_trg_pos;

  logic                 w_store;
  logic                 w_trig;
  logic                 w_wr_ready;
  logic                 w_host_wr;
  logic                 w_grant;
  logic                 w_rd_valid;
  logic                 w_host_rd;
  logic [AW-1:0]        w_wptr_inc;
  logic [AW:0]          w_fill_store;
  logic [AW-1:0]        w_post_inc;
  logic                 w_enter_done;
  logic                 w_store_perm_nxt;
  logic                 w_trg_delayed_nxt;
  logic                 w_load_grant_nxt;
  logic                 w_mem_we;
  logic [TRB_WIDTH-1:0] w_mem_wdata;

  // Qualified events and pointer arithmetic shared by the FSM and datapath.
  // Store permission is only ever high in ARMED/POST, so w_store implies a
  // capture state; pointers are power-of-two sized and wrap by overflow.
  always_comb begin
    w_store      = STORE_I & r_store_perm & ~ARM_I;
    w_trig       = w_store & TRG_EVENT_I & (r_state == S_ARMED);
    w_wr_ready   = (r_state == S_STREAM) & (r_fill != DEPTH_C);
    w_host_wr    = HOST_WR_I & w_wr_ready & ~ARM_I;
    w_grant      = (r_state == S_STREAM) & LOAD_REQUEST_I & (r_fill != '0)
                   & ~r_load_grant & ~ARM_I;
    w_rd_valid   = (r_state == S_DONE) & (r_remain != '0);
    w_host_rd    = HOST_RD_I & w_rd_valid & ~ARM_I;
    w_wptr_inc   = r_wptr + 1'b1;
    w_fill_store = (r_fill == DEPTH_C) ? r_fill : r_fill + 1'b1;
    w_post_inc   = r_post_cnt + 1'b1;
    w_enter_done = (w_trig & (r_delay == '0)) |
                   ((r_state == S_POST) & w_store & (w_post_inc == r_delay));
  end

  // State register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; ARM_I restarts the run from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (ARM_I) begin
      w_state_nxt = MODE_I ? S_STREAM : S_ARMED;
    end else begin
      case (r_state)
        S_ARMED: if (w_trig)       w_state_nxt = (r_delay == '0) ? S_DONE : S_POST;
        S_POST:  if (w_enter_done) w_state_nxt = S_DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Output decode: next values of the registered handshakes follow the next state.
  always_comb begin
    w_store_perm_nxt  = (w_state_nxt == S_ARMED) | (w_state_nxt == S_POST);
    w_trg_delayed_nxt = (w_state_nxt == S_DONE);
    w_load_grant_nxt  = w_grant;
  end

  // Registered Tracer-facing handshakes.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_store_perm  <= 1'b0;
      r_trg_delayed <= 1'b0;
      r_load_grant  <= 1'b0;
    end else begin
      r_store_perm  <= w_store_perm_nxt;
      r_trg_delayed <= w_trg_delayed_nxt;
      r_load_grant  <= w_load_grant_nxt;
    end
  end

  // Pointers, fill/count, trigger latches and the Tracer load data register.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_delay    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fill     <= '0;
      r_post_cnt <= '0;
      r_remain   <= '0;
      r_trg_addr <= '0;
      r_trg_pos  <= '0;
      r_data_o   <= '0;
    end else if (ARM_I) begin
      r_delay    <= DELAY_I;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_fill     <= '0;
      r_post_cnt <= '0;
      r_remain   <= '0;
      r_trg_addr <= '0;
      r_trg_pos  <= '0;
    end else begin
      case (r_state)
        S_ARMED, S_POST: begin
          if (w_store) begin
            r_wptr <= w_wptr_inc;
            r_fill <= w_fill_store;
            if (r_state == S_POST) r_post_cnt <= w_post_inc;
          end
          if (w_trig) begin
            r_trg_addr <= r_wptr;
            r_trg_pos  <= EVENT_POS_I;
            r_post_cnt <= '0;
          end
          // A full buffer has wrapped, so the oldest word sits at the write pointer.
          if (w_enter_done) begin
            r_rptr   <= (w_fill_store == DEPTH_C) ? w_wptr_inc : '0;
            r_remain <= w_fill_store;
          end
        end
        S_DONE: begin
          if (w_host_rd) begin
            r_rptr   <= r_rptr + 1'b1;
            r_remain <= r_remain - 1'b1;
          end
        end
        S_STREAM: begin
          if (w_host_wr) r_wptr <= w_wptr_inc;
          if (w_grant) begin
            r_data_o <= r_mem[r_rptr];
            r_rptr   <= r_rptr + 1'b1;
          end
          case ({w_host_wr, w_grant})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Single write port shared by trace stores and host stream writes.
  always_comb begin
    w_mem_we    = w_store | w_host_wr;
    w_mem_wdata = (r_state == S_STREAM) ? HOST_DATA_I : DATA_I;
  end

  // Word memory; contents are not reset.
  always_ff @(posedge CLK_I) begin
    if (w_mem_we) r_mem[r_wptr] <= w_mem_wdata;
  end

  assign STORE_PERM_O       = r_store_perm;
  assign TRG_DELAYED_O      = r_trg_delayed;
  assign LOAD_GRANT_O       = r_load_grant;
  assign DATA_O             = r_data_o;
  assign HOST_WRITE_READY_O = w_wr_ready;
  assign HOST_READ_VALID_O  = w_rd_valid;
  assign HOST_DATA_O        = w_rd_valid ? r_mem[r_rptr] : '0;
  assign TRG_ADDR_O         = r_trg_addr;
  assign TRG_POS_O          = r_trg_pos;

endmodule

// File: tb/tb_trb_mem_ctrl.sv
// Bench for trb_mem_ctrl with an 8-word memory: trace capture cases from a
// vector table with a readout scoreboard, plus stream FIFO, trigger and
// asynchronous-reset sequences.
module tb_trb_mem_ctrl;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode_i, arm_i, store_i, trg_event_i, load_req_i;
  logic          host_wr_i, host_rd_i;
  logic [AW-1:0] delay_i;
  logic [W-1:0]  data_i, host_data_i;
  logic [PW-1:0] event_pos_i;
  logic          store_perm_o, trg_delayed_o, load_grant_o;
  logic          host_wr_ready_o, host_rd_valid_o;
  logic [W-1:0]  data_o, host_data_o;
  logic [AW-1:0] trg_addr_o;
  logic [PW-1:0] trg_pos_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];

  trb_mem_ctrl #(.TRB_WIDTH(W), .TRB_DEPTH(D)) dut (
    .CLK_I(clk), .RST_I(rst), .MODE_I(mode_i), .ARM_I(arm_i), .DELAY_I(delay_i),
    .STORE_I(store_i), .DATA_I(data_i), .STORE_PERM_O(store_perm_o),
    .TRG_EVENT_I(trg_event_i), .EVENT_POS_I(event_pos_i), .TRG_DELAYED_O(trg_delayed_o),
    .LOAD_REQUEST_I(load_req_i), .LOAD_GRANT_O(load_grant_o), .DATA_O(data_o),
    .HOST_WR_I(host_wr_i), .HOST_DATA_I(host_data_i), .HOST_WRITE_READY_O(host_wr_ready_o),
    .HOST_RD_I(host_rd_i), .HOST_DATA_O(host_data_o), .HOST_READ_VALID_O(host_rd_valid_o),
    .TRG_ADDR_O(trg_addr_o), .TRG_POS_O(trg_pos_o)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic arm(input logic md, input logic [AW-1:0] dly);
    arm_i = 1'b1; mode_i = md; delay_i = dly;
    tick();
    arm_i = 1'b0; mode_i = 1'b0;
  endtask

  task automatic drain_readout(input string nm);
    int n = 0;
    while (host_rd_valid_o && n < 20) begin
      if (sb_q.size() == 0) begin
        check({nm, "_extra_word"}, 32'(host_rd_valid_o), 32'(0));
      end else begin
        check({nm, "_data"}, host_data_o, sb_q.pop_front());
      end
      host_rd_i = 1'b1;
      tick();
      host_rd_i = 1'b0;
      n++;
    end
    check({nm, "_words_left"}, 32'(sb_q.size()), 32'(0));
    check({nm, "_valid_end"}, 32'(host_rd_valid_o), 32'(0));
    sb_q.delete();
  endtask

  typedef struct {
    logic [AW-1:0] delay;
    int            n_att;
    int            trg_idx;
    logic [W-1:0]  base;
    logic [PW-1:0] pos;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int n_stored, first, ngr, cyc;
    logic prev_g;

    vecs[0] = '{delay: 3'd2, n_att: 6,  trg_idx: 2,  base: 32'h10, pos: 5'd7,  exp_addr: 3'd2};
    vecs[1] = '{delay: 3'd1, n_att: 13, trg_idx: 10, base: 32'h00, pos: 5'd3,  exp_addr: 3'd2};
    vecs[2] = '{delay: 3'd0, n_att: 2,  trg_idx: 0,  base: 32'h55, pos: 5'd31, exp_addr: 3'd0};

    rst = 1'b1; mode_i = 0; arm_i = 0; delay_i = '0; store_i = 0; data_i = '0;
    trg_event_i = 0; event_pos_i = '0; load_req_i = 0; host_wr_i = 0;
    host_data_i = '0; host_rd_i = 0;
    tick(); tick();
    check("rst_perm",     32'(store_perm_o),    32'(0));
    check("rst_delayed",  32'(trg_delayed_o),   32'(0));
    check("rst_grant",    32'(load_grant_o),    32'(0));
    check("rst_data_o",   data_o,               32'(0));
    check("rst_wr_ready", 32'(host_wr_ready_o), 32'(0));
    check("rst_rd_valid", 32'(host_rd_valid_o), 32'(0));
    check("rst_host_do",  host_data_o,          32'(0));
    check("rst_trg_addr", 32'(trg_addr_o),      32'(0));
    check("rst_trg_pos",  32'(trg_pos_o),       32'(0));
    rst = 1'b0;
    tick();
    check("idle_perm", 32'(store_perm_o), 32'(0));

    // Trace capture table
    for (int v = 0; v < 3; v++) begin
      arm(1'b0, vecs[v].delay);
      check("arm_perm",     32'(store_perm_o),  32'(1));
      check("arm_delayed",  32'(trg_delayed_o), 32'(0));
      check("arm_trg_addr", 32'(trg_addr_o),    32'(0));
      n_stored = vecs[v].trg_idx + 1 + int'(vecs[v].delay);
      for (int i = 0; i < vecs[v].n_att; i++) begin
        check("store_perm", 32'(store_perm_o), 32'(i < n_stored));
        store_i = 1'b1;
        data_i = vecs[v].base + 32'(i);
        trg_event_i = (i == vecs[v].trg_idx);
        event_pos_i = vecs[v].pos;
        tick();
      end
      store_i = 0; trg_event_i = 0; event_pos_i = '0;
      check("done_perm",    32'(store_perm_o),  32'(0));
      check("done_delayed", 32'(trg_delayed_o), 32'(1));
      check("trg_addr",     32'(trg_addr_o),    32'(vecs[v].exp_addr));
      check("trg_pos",      32'(trg_pos_o),     32'(vecs[v].pos));
      first = (n_stored > D) ? n_stored - D : 0;
      for (int k = first; k < n_stored; k++) sb_q.push_back(vecs[v].base + 32'(k));
      drain_readout("trace");
      check("load_no_grant_trace", 32'(load_grant_o), 32'(0));
    end

    // Stream mode
    arm(1'b1, 3'd0);
    check("str_perm",    32'(store_perm_o),    32'(0));
    check("str_ready",   32'(host_wr_ready_o), 32'(1));
    check("str_rvalid",  32'(host_rd_valid_o), 32'(0));
    for (int i = 0; i < 9; i++) begin
      check("str_fill_ready", 32'(host_wr_ready_o), 32'(i < D));
      host_wr_i = 1'b1; host_data_i = 32'hA0 + 32'(i);
      if (i < D) sb_q.push_back(host_data_i);
      tick();
    end
    host_wr_i = 1'b0;
    check("str_full_ready", 32'(host_wr_ready_o), 32'(0));

    load_req_i = 1'b1; prev_g = load_grant_o; ngr = 0; cyc = 0;
    while (ngr < 3 && cyc < 20) begin
      tick();
      if (load_grant_o) begin
        check("grant_gap", 32'(prev_g), 32'(0));
        check("grant_data", data_o, sb_q.pop_front());
        ngr++;
      end
      prev_g = load_grant_o;
      cyc++;
    end
    load_req_i = 1'b0;
    check("grant_count", 32'(ngr), 32'(3));
    tick();
    check("data_hold_grant", 32'(load_grant_o), 32'(0));
    check("data_hold", data_o, 32'hA2);

    // Simultaneous write and grant with room: count unchanged
    check("wg_ready", 32'(host_wr_ready_o), 32'(1));
    host_wr_i = 1'b1; host_data_i = 32'hB0; load_req_i = 1'b1;
    sb_q.push_back(32'hB0);
    tick();
    host_wr_i = 1'b0; load_req_i = 1'b0;
    check("wg_grant", 32'(load_grant_o), 32'(1));
    check("wg_data", data_o, sb_q.pop_front());
    for (int i = 1; i < 4; i++) begin
      check("wg_refill_ready", 32'(host_wr_ready_o), 32'(1));
      host_wr_i = 1'b1; host_data_i = 32'hB0 + 32'(i);
      sb_q.push_back(host_data_i);
      tick();
    end
    host_wr_i = 1'b0;
    check("wg_full_ready", 32'(host_wr_ready_o), 32'(0));

    // Full FIFO: write alongside a grant is dropped
    host_wr_i = 1'b1; host_data_i = 32'hC0; load_req_i = 1'b1;
    tick();
    host_wr_i = 1'b0; load_req_i = 1'b0;
    check("full_wg_grant", 32'(load_grant_o), 32'(1));
    check("full_wg_data", data_o, sb_q.pop_front());

    // Drain, then a held request with an empty FIFO waits for data
    load_req_i = 1'b1; cyc = 0;
    while (sb_q.size() > 0 && cyc < 40) begin
      tick();
      if (load_grant_o) check("drain_data", data_o, sb_q.pop_front());
      cyc++;
    end
    check("drain_left", 32'(sb_q.size()), 32'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("empty_no_grant", 32'(load_grant_o), 32'(0));
    end
    host_wr_i = 1'b1; host_data_i = 32'hE0;
    tick();
    host_wr_i = 1'b0;
    ngr = 0;
    for (int i = 0; i < 5 && ngr == 0; i++) begin
      tick();
      if (load_grant_o) begin
        check("held_req_data", data_o, 32'hE0);
        ngr++;
      end
    end
    load_req_i = 1'b0;
    check("held_req_granted", 32'(ngr), 32'(1));
    check("str_delayed", 32'(trg_delayed_o), 32'(0));

    // Non-store trigger ignored, then reset asserted mid-POST
    arm(1'b0, 3'd3);
    trg_event_i = 1'b1; event_pos_i = 5'd4;
    tick();
    trg_event_i = 1'b0;
    check("nostore_trg_addr", 32'(trg_addr_o), 32'(0));
    check("nostore_trg_pos",  32'(trg_pos_o),  32'(0));
    store_i = 1'b1; data_i = 32'h77;
    tick();
    data_i = 32'h78; trg_event_i = 1'b1; event_pos_i = 5'd9;
    tick();
    trg_event_i = 1'b0;
    check("post_trg_addr", 32'(trg_addr_o), 32'(1));
    check("post_trg_pos",  32'(trg_pos_o),  32'(9));
    data_i = 32'h79;
    tick();
    store_i = 1'b0;
    check("post_perm", 32'(store_perm_o), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    check("async_perm",     32'(store_perm_o),  32'(0));
    check("async_delayed",  32'(trg_delayed_o), 32'(0));
    check("async_grant",    32'(load_grant_o),  32'(0));
    check("async_trg_addr", 32'(trg_addr_o),    32'(0));
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_perm", 32'(store_perm_o), 32'(0));
    store_i = 1'b1; data_i = 32'h99; trg_event_i = 1'b1;
    tick(); tick();
    store_i = 1'b0; trg_event_i = 1'b0;
    check("idle_store_perm",    32'(store_perm_o),    32'(0));
    check("idle_store_delayed", 32'(trg_delayed_o),   32'(0));
    check("idle_store_trg",     32'(trg_addr_o),      32'(0));
    check("idle_rvalid",        32'(host_rd_valid_o), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
